// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param
// Description : Single-clock synchronous FIFO with a registered request-
//               classification state machine, registered read data, an
//               occupancy count, full/empty/almost flags and per-request
//               acknowledge/error pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1           rising-edge clock
//   reset_n       in   1           asynchronous active-low reset
//   wr_en         in   1           write request
//   rd_en         in   1           read request
//   d_in          in   DATA_WIDTH  write data, sampled with wr_en
//   d_out         out  DATA_WIDTH  registered read data
//   data_count    out  CNT_W       stored entries, 0..DEPTH
//   full/empty    out  1           count==DEPTH / count==0
//   almost_full   out  1           count>=AFULL_LVL
//   almost_empty  out  1           count<=AEMPTY_LVL
//   wr_ack/wr_err out  1           write accepted / rejected (one cycle late)
//   rd_ack/rd_err out  1           read accepted / rejected (one cycle late)
// ============================================================================
module fifo_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AFULL_LVL  = DEPTH - 1,
    parameter int unsigned AEMPTY_LVL = 1,
    localparam int unsigned ADDR_W    = $clog2(DEPTH),
    localparam int unsigned CNT_W     = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic [CNT_W-1:0]      data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AFULL  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] C_AEMPTY = CNT_W'(AEMPTY_LVL);

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        NO_OP    = 4'd1,
        WRITE    = 4'd2,
        READ     = 4'd3,
        WR_RD    = 4'd4,
        WR_ERR   = 4'd5,
        RD_ERR   = 4'd6,
        WR_RDERR = 4'd7,
        RD_WRERR = 4'd8
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic is_full;
    logic is_empty;
    logic do_wr;
    logic do_rd;

    assign is_full  = (count_q == C_DEPTH);
    assign is_empty = (count_q == '0);

    // Classify the request pair against the current occupancy. The chosen
    // state also decides which accesses are performed on this edge.
    always_comb begin
        state_d = NO_OP;
        case ({wr_en, rd_en})
            2'b00:   state_d = NO_OP;
            2'b10:   state_d = is_full  ? WR_ERR : WRITE;
            2'b01:   state_d = is_empty ? RD_ERR : READ;
            2'b11: begin
                // Empty: no fall-through of the word being written.
                // Full: the slot freed by the read is not reused this cycle.
                if (is_empty)     state_d = WR_RDERR;
                else if (is_full) state_d = RD_WRERR;
                else              state_d = WR_RD;
            end
            default: state_d = NO_OP;
        endcase
    end

    assign do_wr = (state_d == WRITE) || (state_d == WR_RD) || (state_d == WR_RDERR);
    assign do_rd = (state_d == READ)  || (state_d == WR_RD) || (state_d == RD_WRERR);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        // DEPTH is a power of two, so pointer wrap is the natural overflow.
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is not reset; occupancy tracking keeps stale words unreachable.
    always_ff @(posedge clk) begin
        if (do_wr && reset_n) begin
            mem_q[wr_ptr_q] <= d_in;
        end
    end

    assign d_out        = dout_q;
    assign data_count   = count_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (count_q >= C_AFULL);
    assign almost_empty = (count_q <= C_AEMPTY);

    // Status pulses come straight from the state register, so they lag the
    // sampling edge by one cycle and repeat while the same request repeats.
    assign wr_ack = (state_q == WRITE)  || (state_q == WR_RD) || (state_q == WR_RDERR);
    assign rd_ack = (state_q == READ)   || (state_q == WR_RD) || (state_q == RD_WRERR);
    assign wr_err = (state_q == WR_ERR) || (state_q == RD_WRERR);
    assign rd_err = (state_q == RD_ERR) || (state_q == WR_RDERR);

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_param
// Description : Directed self-checking bench for fifo_param with default
//               parameters (DATA_WIDTH=32, DEPTH=8, AFULL_LVL=7, AEMPTY_LVL=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic [3:0]  data_count;
    logic        full, empty, almost_full, almost_empty;
    logic        wr_ack, wr_err, rd_ack, rd_err;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_param dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .d_in         (d_in),
        .d_out        (d_out),
        .data_count   (data_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Status bundle {wr_ack, wr_err, rd_ack, rd_err}
    task automatic check_st(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, wr_ack, wr_err, rd_ack, rd_err}, {28'd0, exp});
    endtask

    // Flag bundle {full, empty, almost_full, almost_empty}
    task automatic check_fl(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, full, empty, almost_full, almost_empty}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_word;
        logic [3:0]  exp_fl;

        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        d_in    = 32'd0;
        #12;
        check("rst_count", {28'd0, data_count}, 32'd0);
        check("rst_dout", d_out, 32'd0);
        check_st("rst_status", 4'b0000);
        check_fl("rst_flags", 4'b0101);
        reset_n = 1'b1;

        // Fill with 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            d_in  = 32'h11 * (i + 1);
            tick();
            check_st("fill_status", 4'b1000);
            check("fill_count", {28'd0, data_count}, i + 1);
            exp_fl = {(i + 1) == 8, 1'b0, (i + 1) >= 7, (i + 1) <= 1};
            check_fl("fill_flags", exp_fl);
        end

        // Write into a full FIFO is rejected
        d_in = 32'h99;
        tick();
        check_st("ovf_status", 4'b0100);
        check("ovf_count", {28'd0, data_count}, 32'd8);
        check_fl("ovf_flags", 4'b1010);

        // Drain: data in order, 0x99 never appears
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            tick();
            check_st("drain_status", 4'b0010);
            check("drain_data", d_out, 32'h11 * (i + 1));
            check("drain_count", {28'd0, data_count}, 7 - i);
        end
        check_fl("drain_flags", 4'b0101);

        // Read from empty is rejected, d_out holds
        tick();
        check_st("unf_status", 4'b0001);
        check("unf_dout", d_out, 32'h88);
        check_fl("unf_flags", 4'b0101);

        // Simultaneous write+read while empty: write only
        wr_en = 1'b1;
        d_in  = 32'hA1;
        tick();
        check_st("wrrderr_status", 4'b1001);
        check("wrrderr_count", {28'd0, data_count}, 32'd1);
        check("wrrderr_dout", d_out, 32'h88);

        // Bring count to 4: queue A1 A2 A3 A4
        rd_en = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            d_in = 32'hA0 + i;
            tick();
        end
        check("cnt4", {28'd0, data_count}, 32'd4);

        // 10 cycles of simultaneous write+read, pointers wrap
        rd_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d_in = 32'hB0 + k;
            tick();
            exp_word = (k < 4) ? (32'hA1 + k) : (32'hB0 + k - 4);
            check_st("wr_rd_status", 4'b1010);
            check("wr_rd_data", d_out, exp_word);
            check("wr_rd_count", {28'd0, data_count}, 32'd4);
        end

        // Queue is B6 B7 B8 B9; fill with C0..C3
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_in = 32'hC0 + i;
            tick();
        end
        check("cnt8", {28'd0, data_count}, 32'd8);
        check_fl("cnt8_flags", 4'b1010);

        // Full + write+read: read accepted, write rejected
        rd_en = 1'b1;
        d_in  = 32'hDD;
        tick();
        check_st("rdwrerr_status", 4'b0110);
        check("rdwrerr_count", {28'd0, data_count}, 32'd7);
        check("rdwrerr_dout", d_out, 32'hB6);

        // Two reads -> count 5
        wr_en = 1'b0;
        tick();
        check("rd_b7", d_out, 32'hB7);
        tick();
        check("rd_b8", d_out, 32'hB8);
        check("cnt5", {28'd0, data_count}, 32'd5);
        check_st("pre_rst_status", 4'b0010);

        // Asynchronous reset between edges
        reset_n = 1'b0;
        #2;
        check("arst_count", {28'd0, data_count}, 32'd0);
        check("arst_dout", d_out, 32'd0);
        check_st("arst_status", 4'b0000);
        check_fl("arst_flags", 4'b0101);
        reset_n = 1'b1;

        // First edge after release: read on empty -> rd_err
        tick();
        check_st("post_rst_status", 4'b0001);
        check("post_rst_dout", d_out, 32'd0);
        check("post_rst_count", {28'd0, data_count}, 32'd0);

        // Idle cycle clears status
        rd_en = 1'b0;
        tick();
        check_st("noop_status", 4'b0000);

        // Stored entries were discarded: new word is the one read back
        wr_en = 1'b1;
        d_in  = 32'h5A;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        check("fresh_data", d_out, 32'h5A);
        check("fresh_count", {28'd0, data_count}, 32'd0);
        rd_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of d_in/d_out.
REQ-002 Parameter DEPTH, default 8: entry count; power of two, 2..256.
REQ-003 Parameter AFULL_LVL, default DEPTH-1: almost_full threshold, 1..DEPTH.
REQ-004 Parameter AEMPTY_LVL, default 1: almost_empty threshold, 0..DEPTH-1.
REQ-005 Derived ADDR_W = clog2(DEPTH) and CNT_W = ADDR_W+1.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 wr_en  in  1  write request, sampled at rising clk.
REQ-010 rd_en  in  1  read request, sampled at rising clk.
REQ-011 d_in  in  DATA_WIDTH  write data, sampled with wr_en.
REQ-012 d_out  out  DATA_WIDTH  registered read data.
REQ-013 data_count  out  CNT_W  number of stored entries, 0..DEPTH.
REQ-014 full / empty  out  1 each  count==DEPTH / count==0.
REQ-015 almost_full / almost_empty  out  1 each  count>=AFULL_LVL / count<=AEMPTY_LVL.
REQ-016 wr_ack, wr_err, rd_ack, rd_err  out  1 each  per-request status pulses.

Function
REQ-017 The block SHALL hold a state register with states INIT, NO_OP, WRITE, READ, WR_RD, WR_ERR, RD_ERR, WR_RDERR, RD_WRERR.
REQ-018 Next state SHALL be chosen from (wr_en, rd_en, data_count) at each rising clk, from any state:
  - neither: NO_OP
  - wr only: count<DEPTH -> WRITE, else WR_ERR
  - rd only: count>0 -> READ, else RD_ERR
  - both, 0<count<DEPTH -> WR_RD
  - both, count==0 -> WR_RDERR (write accepted, read rejected; no fall-through)
  - both, count==DEPTH -> RD_WRERR (read accepted, write rejected; freed slot not reused same cycle).
REQ-019 Accepted write SHALL store d_in at wr_ptr and advance wr_ptr by 1, wrapping DEPTH-1 -> 0.
REQ-020 Accepted read SHALL load mem[rd_ptr] into d_out and advance rd_ptr by 1, wrapping DEPTH-1 -> 0.
REQ-021 d_out SHALL hold its value on every edge without an accepted read.
REQ-022 data_count SHALL update on the same edge: +1 on write only, -1 on read only, unchanged for WR_RD or no accepted access.
REQ-023 Rejected requests SHALL change no pointer, count, memory word or d_out.
REQ-024 Status outputs SHALL be decoded from the state register only, one cycle after the sampling edge:
  - wr_ack=1 in WRITE, WR_RD, WR_RDERR
  - rd_ack=1 in READ, WR_RD, RD_WRERR
  - wr_err=1 in WR_ERR, RD_WRERR
  - rd_err=1 in RD_ERR, WR_RDERR
  - all 0 in INIT, NO_OP.
REQ-025 Each status output SHALL stay asserted for consecutive cycles while the same request repeats.
REQ-026 full, empty, almost_full, almost_empty SHALL be combinational from the data_count register.
REQ-027 Full and empty SHALL never be asserted together.
REQ-028 Rejected write while full SHALL leave full=1; rejected read while empty SHALL leave empty=1.

Reset
REQ-029 reset_n=0 SHALL immediately force state=INIT, wr_ptr=rd_ptr=0, data_count=0, d_out=0, and all status outputs 0.
REQ-030 During reset: empty=1, full=0, almost_empty=1, almost_full=(AFULL_LVL==0?1:0), i.e. 0 for legal parameters.
REQ-031 Memory contents are not reset; stale data SHALL never reach d_out.
REQ-032 Reset asserted mid-burst SHALL discard all stored entries; the first edge after release SHALL follow REQ-018.

Verification (DEPTH=8, DATA_WIDTH=32, defaults)
REQ-033 Scenario: reset, then 8 writes of 0x11..0x88 -> wr_ack=1 for 8 cycles, count 1..8, almost_full at 7, full at 8.
REQ-034 Scenario: full FIFO, 9th write of 0x99 -> wr_err=1, wr_ack=0, count stays 8; the following 8 reads return 0x11..0x88 in order, never 0x99.
REQ-035 Scenario: empty FIFO, read -> rd_err=1, d_out unchanged, empty stays 1; next, wr+rd together -> WR_RDERR, wr_ack=rd_err=1, count=1.
REQ-036 Scenario: count=4, wr+rd for 10 cycles -> wr_ack=rd_ack=1 each cycle, count stays 4, pointers wrap, read data in FIFO order.
REQ-037 Scenario: count=8, wr+rd -> rd_ack=wr_err=1, count=7, oldest word on d_out.
REQ-038 Scenario: count=5, reset_n pulsed low between edges -> outputs clear asynchronously; after release a read yields rd_err=1.
